// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// Entries store destination indices at a fixed maximum width so the struct stays non-parametric.
package fwd_hazard_unit_pkg;

   localparam int REG_W_MAX = 8;
   localparam int FWD_RF    = 0;

   typedef struct packed {
      logic                 valid;
      logic                 wr;
      logic                 ld;
      logic [REG_W_MAX-1:0] dst;
   } entry_t;

   function automatic int fwd_width(input int stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Priority-encoded forwarding select for one ID source operand.
// The youngest matching producer (lowest stage index) wins.
module fwd_match
   import fwd_hazard_unit_pkg::*;
#(
   parameter int STAGES   = 3,
   parameter int LOAD_LAT = 1,
   parameter int ZERO_REG = 0,
   parameter int FWD_W    = fwd_width(STAGES)
) (
   input  logic [REG_W_MAX-1:0] src,
   input  logic                 src_used,
   input  entry_t               ent [1:STAGES],
   output logic [FWD_W-1:0]     sel,
   output logic                 load_use
);

   logic src_is_zero;

   assign src_is_zero = (ZERO_REG != 0) && (src == '0);

   // Scan oldest to youngest so the youngest match overwrites the result.
   always_comb begin
      sel      = FWD_W'(FWD_RF);
      load_use = 1'b0;
      for (int k = STAGES; k >= 1; k--) begin
         if (src_used && !src_is_zero && ent[k].valid && ent[k].wr &&
             (ent[k].dst == src)) begin
            sel      = FWD_W'(k);
            load_use = ent[k].ld && (k <= LOAD_LAT);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for an in-order pipeline,
// tracking the instructions in the stages downstream of decode.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int REG_W    = 3,
   parameter int STAGES   = 3,
   parameter int LOAD_LAT = 1,
   parameter int ZERO_REG = 0,
   parameter int CNT_W    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_valid,
   input  logic [REG_W-1:0]              id_rs,
   input  logic [REG_W-1:0]              id_rt,
   input  logic                          id_rs_used,
   input  logic                          id_rt_used,
   input  logic [REG_W-1:0]              id_dst,
   input  logic                          id_wr,
   input  logic                          id_mem_rd,
   input  logic                          flush,
   input  logic                          hold,
   output logic                          stall,
   output logic [fwd_width(STAGES)-1:0]  rs_fwd,
   output logic [fwd_width(STAGES)-1:0]  rt_fwd,
   output logic [CNT_W-1:0]              stall_cnt
);

   localparam int FWD_W = fwd_width(STAGES);

   entry_t               ent [1:STAGES];
   entry_t               id_ent;
   logic [FWD_W-1:0]     rs_sel;
   logic [FWD_W-1:0]     rt_sel;
   logic                 rs_lu;
   logic                 rt_lu;
   logic                 issue;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      id_ent       = '0;
      id_ent.valid = 1'b1;
      id_ent.wr    = id_wr;
      id_ent.ld    = id_mem_rd;
      id_ent.dst   = REG_W_MAX'(id_dst);
   end

   fwd_match #(
      .STAGES   (STAGES),
      .LOAD_LAT (LOAD_LAT),
      .ZERO_REG (ZERO_REG),
      .FWD_W    (FWD_W)
   ) u_rs_match (
      .src      (REG_W_MAX'(id_rs)),
      .src_used (id_rs_used),
      .ent      (ent),
      .sel      (rs_sel),
      .load_use (rs_lu)
   );

   fwd_match #(
      .STAGES   (STAGES),
      .LOAD_LAT (LOAD_LAT),
      .ZERO_REG (ZERO_REG),
      .FWD_W    (FWD_W)
   ) u_rt_match (
      .src      (REG_W_MAX'(id_rt)),
      .src_used (id_rt_used),
      .ent      (ent),
      .sel      (rt_sel),
      .load_use (rt_lu)
   );

   // Flush squashes the ID instruction, so it can never stall.
   assign stall  = id_valid && !flush && (rs_lu || rt_lu);
   assign issue  = id_valid && !stall && !flush;
   assign rs_fwd = stall ? FWD_W'(FWD_RF) : rs_sel;
   assign rt_fwd = stall ? FWD_W'(FWD_RF) : rt_sel;

   // Stage boundary: ID -> EX and down the tracked stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= STAGES; k++) begin
            ent[k].valid <= 1'b0;
            ent[k].wr    <= 1'b0;
            ent[k].ld    <= 1'b0;
         end
         stall_cnt <= '0;
      end else if (!hold) begin
         for (int k = STAGES; k >= 2; k--) begin
            ent[k] <= ent[k-1];
         end
         if (issue) begin
            ent[1] <= id_ent;
         end else begin
            ent[1].valid <= 1'b0;
            ent[1].wr    <= 1'b0;
            ent[1].ld    <= 1'b0;
         end
         if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
         end
      end
   end

endmodule
